maquina_pintar_bandas: RTL and testbench

//  Parametrised successor of the drum-lane paint FSM. It decodes the player lane requests,

---
 rtl/maquina_pintar_bandas_if.sv | 30 +++
 rtl/maquina_pintar_bandas.sv | 158 +++++++++++++++
 tb/tb_maquina_pintar_bandas.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/maquina_pintar_bandas_if.sv
// Player-facing bus of the lane painter: request/mode inputs from the pad
// synchroniser and the highlight/colour/hit outputs towards the painter.
interface maquina_pintar_bandas_if #(
    parameter int N_BANDAS = 5,
    parameter int COLOR_W  = 3,
    parameter int CNT_W    = 8
);
    localparam int IDX_W = (N_BANDAS > 1) ? $clog2(N_BANDAS) : 1;

    logic                inicio;
    logic                estatica_req;
    logic [N_BANDAS-1:0] banda_req;
    logic                modo;
    logic [COLOR_W-1:0]  color_banda;
    logic [COLOR_W-1:0]  color_res;
    logic [N_BANDAS:0]   salida;
    logic                hit_valid;
    logic [IDX_W-1:0]    hit_idx;
    logic [CNT_W-1:0]    aciertos;

    modport master (
        output inicio, estatica_req, banda_req, modo, color_banda,
        input  color_res, salida, hit_valid, hit_idx, aciertos
    );

    modport slave (
        input  inicio, estatica_req, banda_req, modo, color_banda,
        output color_res, salida, hit_valid, hit_idx, aciertos
    );
endinterface

// File: rtl/maquina_pintar_bandas.sv
// Drum-lane paint FSM: debounces single-lane hits, drives a one-hot lane
// highlight plus colour code, and counts accepted hits (saturating).
// All outputs are registered and decoded from the next state.
module maquina_pintar_bandas #(
    parameter int N_BANDAS  = 5,
    parameter int COLOR_W   = 3,
    parameter int MIN_HOLD  = 2,
    parameter int PULSE_LEN = 8,
    parameter int CNT_W     = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    maquina_pintar_bandas_if.slave    bus
);
    localparam int IDX_W  = (N_BANDAS > 1) ? $clog2(N_BANDAS) : 1;
    localparam int HOLD_W = (MIN_HOLD > 1) ? $clog2(MIN_HOLD) : 1;
    localparam int TMR_W  = $clog2(PULSE_LEN + 1);

    typedef enum logic [2:0] {INICIAL, PINTAR, ESTATICA, FILTRO, BANDA} estado_t;

    estado_t             estado_q, estado_d;
    logic [IDX_W-1:0]    cand_q, cand_d;
    logic [HOLD_W-1:0]   cnt_q, cnt_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic [N_BANDAS-1:0] armed_q, armed_d;
    logic                modo_q, modo_d;
    logic [IDX_W-1:0]    hit_idx_q, hit_idx_d;
    logic [CNT_W-1:0]    aciertos_q, aciertos_d;
    logic                hit_valid_q, hit_valid_d;
    logic [N_BANDAS:0]   salida_q, salida_d;
    logic [COLOR_W-1:0]  color_q, color_d;

    logic                req_onehot;
    logic [IDX_W-1:0]    req_idx;
    logic [N_BANDAS-1:0] cand_oh;

    // Decode whether exactly one lane is requested and which one
    always_comb begin
        req_onehot = 1'b0;
        req_idx    = '0;
        for (int i = 0; i < N_BANDAS; i++) begin
            if (bus.banda_req == (N_BANDAS'(1) << i)) begin
                req_onehot = 1'b1;
                req_idx    = IDX_W'(i);
            end
        end
    end

    assign cand_oh = N_BANDAS'(1) << cand_q;

    // Next-state, hit bookkeeping and Moore output decode of the next state
    always_comb begin
        estado_d    = estado_q;
        cand_d      = cand_q;
        cnt_d       = cnt_q;
        timer_d     = timer_q;
        modo_d      = modo_q;
        hit_idx_d   = hit_idx_q;
        aciertos_d  = aciertos_q;
        hit_valid_d = 1'b0;
        // any released lane becomes eligible again
        armed_d     = armed_q | ~bus.banda_req;

        case (estado_q)
            INICIAL: begin
                if (bus.inicio && !bus.estatica_req && bus.banda_req == '0) begin
                    estado_d   = PINTAR;
                    aciertos_d = '0;
                end
            end
            PINTAR: begin
                if (bus.estatica_req) begin
                    estado_d = ESTATICA;
                end else if (req_onehot && armed_q[req_idx]) begin
                    cand_d   = req_idx;
                    cnt_d    = '0;
                    estado_d = FILTRO;
                end
            end
            ESTATICA: begin
                if (!bus.estatica_req) estado_d = PINTAR;
            end
            FILTRO: begin
                if (bus.banda_req != cand_oh) begin
                    estado_d = PINTAR;
                    cnt_d    = '0;
                end else if (cnt_q == HOLD_W'(MIN_HOLD - 1)) begin
                    estado_d    = BANDA;
                    hit_valid_d = 1'b1;
                    hit_idx_d   = cand_q;
                    if (aciertos_q != '1) aciertos_d = aciertos_q + 1'b1;
                    modo_d      = bus.modo;
                    timer_d     = TMR_W'(PULSE_LEN);
                    // pulse mode: the held lane must be released before it can hit again
                    if (bus.modo) armed_d[cand_q] = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            BANDA: begin
                if (modo_q) begin
                    if (timer_q == TMR_W'(1)) estado_d = PINTAR;
                    else                      timer_d  = timer_q - 1'b1;
                end else if (bus.banda_req != cand_oh) begin
                    estado_d = PINTAR;
                end
            end
            default: estado_d = INICIAL;
        endcase

        salida_d = '0;
        color_d  = '0;
        case (estado_d)
            PINTAR, FILTRO: color_d = '1;
            ESTATICA: begin
                salida_d[0] = 1'b1;
                color_d     = bus.color_banda;
            end
            BANDA:    salida_d = ((N_BANDAS + 1)'(1) << cand_d) << 1;
            default:  ;
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado_q    <= INICIAL;
            cand_q      <= '0;
            cnt_q       <= '0;
            timer_q     <= '0;
            armed_q     <= '1;
            modo_q      <= 1'b0;
            hit_idx_q   <= '0;
            aciertos_q  <= '0;
            hit_valid_q <= 1'b0;
            salida_q    <= '0;
            color_q     <= '0;
        end else begin
            estado_q    <= estado_d;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            timer_q     <= timer_d;
            armed_q     <= armed_d;
            modo_q      <= modo_d;
            hit_idx_q   <= hit_idx_d;
            aciertos_q  <= aciertos_d;
            hit_valid_q <= hit_valid_d;
            salida_q    <= salida_d;
            color_q     <= color_d;
        end
    end

    assign bus.salida    = salida_q;
    assign bus.color_res = color_q;
    assign bus.hit_valid = hit_valid_q;
    assign bus.hit_idx   = hit_idx_q;
    assign bus.aciertos  = aciertos_q;
endmodule

// File: tb/tb_maquina_pintar_bandas.sv
// Bench for the lane painter: hand-computed vector table, multi-cycle corner
// sequences and random stimulus against a behavioural reference model.
module tb_maquina_pintar_bandas;
    localparam int N   = 5;
    localparam int CW  = 3;
    localparam int MH  = 2;
    localparam int PL  = 8;
    localparam int CNW = 8;
    localparam int IW  = 3;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    maquina_pintar_bandas_if #(.N_BANDAS(N), .COLOR_W(CW), .CNT_W(CNW)) bus ();

    maquina_pintar_bandas #(
        .N_BANDAS(N), .COLOR_W(CW), .MIN_HOLD(MH), .PULSE_LEN(PL), .CNT_W(CNW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // phase: 0 waiting for start, 1 painting, 2 static band, 3 debouncing, 4 lane lit
    int         m_ph, m_lane, m_held, m_left, m_hits, m_idx;
    bit         m_pulse, m_hit;
    bit [N-1:0] m_block;
    logic [CW-1:0] m_col;

    task automatic model_reset();
        m_ph = 0; m_lane = 0; m_held = 0; m_left = 0; m_hits = 0; m_idx = 0;
        m_pulse = 0; m_hit = 0; m_block = '0; m_col = '0;
    endtask

    task automatic model_step();
        logic [N-1:0] req;
        int nreq, lane;
        req  = bus.banda_req;
        nreq = $countones(req);
        lane = 0;
        for (int i = 0; i < N; i++) if (req[i]) lane = i;
        m_hit = 0;
        m_col = bus.color_banda;
        case (m_ph)
            0: if (bus.inicio && !bus.estatica_req && nreq == 0) begin m_ph = 1; m_hits = 0; end
            1: if (bus.estatica_req) m_ph = 2;
               else if (nreq == 1 && !m_block[lane]) begin m_ph = 3; m_lane = lane; m_held = 1; end
            2: if (!bus.estatica_req) m_ph = 1;
            3: if (!(nreq == 1 && lane == m_lane)) m_ph = 1;
               else if (m_held >= MH) begin
                   m_ph = 4; m_hit = 1; m_idx = m_lane;
                   m_hits = (m_hits + 1 > 255) ? 255 : m_hits + 1;
                   m_pulse = bus.modo; m_left = PL;
                   if (bus.modo) m_block[m_lane] = 1;
               end else m_held++;
            4: if (m_pulse) begin
                   if (m_left == 1) m_ph = 1; else m_left--;
               end else if (!(nreq == 1 && lane == m_lane)) m_ph = 1;
            default: ;
        endcase
        for (int k = 0; k < N; k++) if (!req[k]) m_block[k] = 0;
    endtask

    function automatic logic [N:0] m_salida();
        logic [N:0] s;
        s = '0;
        if (m_ph == 2) s[0] = 1'b1;
        if (m_ph == 4) s[m_lane+1] = 1'b1;
        return s;
    endfunction

    function automatic logic [CW-1:0] m_color();
        case (m_ph)
            1, 3:    return '1;
            2:       return m_col;
            default: return '0;
        endcase
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_model();
        chk("mdl_salida",    32'(bus.salida),    32'(m_salida()));
        chk("mdl_color_res", 32'(bus.color_res), 32'(m_color()));
        chk("mdl_hit_valid", 32'(bus.hit_valid), 32'(m_hit));
        chk("mdl_hit_idx",   32'(bus.hit_idx),   32'(m_idx));
        chk("mdl_aciertos",  32'(bus.aciertos),  32'(m_hits));
    endtask

    // one clock: model follows the DUT edge, outputs compared on the falling edge
    task automatic tick();
        @(posedge clk);
        if (!reset) model_reset(); else model_step();
        @(negedge clk);
        chk_model();
    endtask

    task automatic drive(input logic ini, input logic est, input logic [N-1:0] req,
                         input logic md, input logic [CW-1:0] col);
        bus.inicio = ini; bus.estatica_req = est; bus.banda_req = req;
        bus.modo = md; bus.color_banda = col;
    endtask

    typedef struct {
        logic          ini;
        logic          est;
        logic [N-1:0]  req;
        logic          md;
        logic [CW-1:0] col;
        logic [N:0]    e_sal;
        logic [CW-1:0] e_col;
        logic          e_hv;
        logic [IW-1:0] e_idx;
        logic [CNW-1:0] e_acc;
    } vec_t;

    vec_t tbl [16];
    int   hv_cnt, lit_cnt;

    initial begin
        // inputs -> outputs after the edge
        tbl[0]  = '{1'b1, 1'b0, 5'b00000, 1'b0, 3'b000, 6'b000000, 3'b111, 1'b0, 3'd0, 8'd0};
        tbl[1]  = '{1'b0, 1'b0, 5'b00100, 1'b0, 3'b000, 6'b000000, 3'b111, 1'b0, 3'd0, 8'd0};
        tbl[2]  = '{1'b0, 1'b0, 5'b00100, 1'b0, 3'b000, 6'b000000, 3'b111, 1'b0, 3'd0, 8'd0};
        tbl[3]  = '{1'b0, 1'b0, 5'b00100, 1'b0, 3'b000, 6'b001000, 3'b000, 1'b1, 3'd2, 8'd1};
        tbl[4]  = '{1'b0, 1'b0, 5'b00100, 1'b0, 3'b000, 6'b001000, 3'b000, 1'b0, 3'd2, 8'd1};
        tbl[5]  = '{1'b0, 1'b0, 5'b00100, 1'b0, 3'b000, 6'b001000, 3'b000, 1'b0, 3'd2, 8'd1};
        tbl[6]  = '{1'b0, 1'b0, 5'b00000, 1'b0, 3'b000, 6'b000000, 3'b111, 1'b0, 3'd2, 8'd1};
        tbl[7]  = '{1'b0, 1'b0, 5'b00010, 1'b0, 3'b000, 6'b000000, 3'b111, 1'b0, 3'd2, 8'd1};
        tbl[8]  = '{1'b0, 1'b0, 5'b00000, 1'b0, 3'b000, 6'b000000, 3'b111, 1'b0, 3'd2, 8'd1};
        tbl[9]  = '{1'b0, 1'b1, 5'b00001, 1'b0, 3'b101, 6'b000001, 3'b101, 1'b0, 3'd2, 8'd1};
        tbl[10] = '{1'b0, 1'b1, 5'b00001, 1'b0, 3'b101, 6'b000001, 3'b101, 1'b0, 3'd2, 8'd1};
        tbl[11] = '{1'b0, 1'b0, 5'b00000, 1'b0, 3'b101, 6'b000000, 3'b111, 1'b0, 3'd2, 8'd1};
        tbl[12] = '{1'b0, 1'b0, 5'b00011, 1'b0, 3'b000, 6'b000000, 3'b111, 1'b0, 3'd2, 8'd1};
        tbl[13] = '{1'b0, 1'b0, 5'b00011, 1'b0, 3'b000, 6'b000000, 3'b111, 1'b0, 3'd2, 8'd1};
        tbl[14] = '{1'b0, 1'b0, 5'b00000, 1'b0, 3'b000, 6'b000000, 3'b111, 1'b0, 3'd2, 8'd1};
        tbl[15] = '{1'b1, 1'b0, 5'b00000, 1'b0, 3'b000, 6'b000000, 3'b111, 1'b0, 3'd2, 8'd1};

        reset = 1'b0;
        drive(0, 0, '0, 0, '0);
        model_reset();
        @(negedge clk);
        chk("rst_salida",    32'(bus.salida),    32'd0);
        chk("rst_color_res", 32'(bus.color_res), 32'd0);
        chk("rst_hit_valid", 32'(bus.hit_valid), 32'd0);
        chk("rst_hit_idx",   32'(bus.hit_idx),   32'd0);
        chk("rst_aciertos",  32'(bus.aciertos),  32'd0);
        reset = 1'b1;

        // table-driven vectors: start, held hit, short glitch, static band, multi-lane
        for (int r = 0; r < 16; r++) begin
            drive(tbl[r].ini, tbl[r].est, tbl[r].req, tbl[r].md, tbl[r].col);
            tick();
            chk($sformatf("row%0d_salida", r),    32'(bus.salida),    32'(tbl[r].e_sal));
            chk($sformatf("row%0d_color_res", r), 32'(bus.color_res), 32'(tbl[r].e_col));
            chk($sformatf("row%0d_hit_valid", r), 32'(bus.hit_valid), 32'(tbl[r].e_hv));
            chk($sformatf("row%0d_hit_idx", r),   32'(bus.hit_idx),   32'(tbl[r].e_idx));
            chk($sformatf("row%0d_aciertos", r),  32'(bus.aciertos),  32'(tbl[r].e_acc));
        end

        // pulse mode: lane 0 held 20 cycles -> exactly 8 lit cycles, one hit
        hv_cnt = 0; lit_cnt = 0;
        drive(0, 0, 5'b00001, 1, '0);
        for (int c = 0; c < 20; c++) begin
            tick();
            if (bus.hit_valid) hv_cnt++;
            if (bus.salida == 6'b000010) lit_cnt++;
        end
        chk("pulse_lit_cycles", 32'(lit_cnt), 32'd8);
        chk("pulse_hits",       32'(hv_cnt),  32'd1);
        // release one cycle and press again -> re-armed, second hit
        drive(0, 0, 5'b00000, 1, '0);
        tick();
        hv_cnt = 0;
        drive(0, 0, 5'b00001, 1, '0);
        for (int c = 0; c < 6; c++) begin
            tick();
            if (bus.hit_valid) hv_cnt++;
        end
        chk("pulse_rearm_hits", 32'(hv_cnt), 32'd1);
        drive(0, 0, 5'b00000, 0, '0);
        for (int c = 0; c < 10; c++) tick();
        chk("pulse_aciertos", 32'(bus.aciertos), 32'd3);

        // reset in the middle of a lit lane
        drive(0, 0, 5'b01000, 0, '0);
        for (int c = 0; c < 4; c++) tick();
        chk("banda_lane3", 32'(bus.salida), 32'b010000);
        reset = 1'b0;
        #1;
        chk("midrst_salida",    32'(bus.salida),    32'd0);
        chk("midrst_color_res", 32'(bus.color_res), 32'd0);
        chk("midrst_aciertos",  32'(bus.aciertos),  32'd0);
        chk("midrst_hit_valid", 32'(bus.hit_valid), 32'd0);
        model_reset();
        drive(0, 0, 5'b00000, 0, '0);
        tick();
        tick();
        @(negedge clk);
        reset = 1'b1;
        drive(1, 0, 5'b00000, 0, '0);
        tick();
        chk("restart_color_res", 32'(bus.color_res), 32'b111);
        drive(0, 0, 5'b00000, 0, '0);

        // saturating hit counter: 260 accepted hits
        for (int h = 0; h < 260; h++) begin
            drive(0, 0, 5'(1 << (h % N)), 0, '0);
            tick(); tick(); tick();
            drive(0, 0, 5'b00000, 0, '0);
            tick();
        end
        chk("sat_aciertos", 32'(bus.aciertos), 32'd255);
        drive(0, 0, 5'b00011, 0, '0);
        tick(); tick();
        chk("multi_salida",    32'(bus.salida),    32'd0);
        chk("multi_color_res", 32'(bus.color_res), 32'b111);

        // random stimulus against the model
        begin
            logic [N-1:0] rq;
            logic md, est;
            rq = '0; md = 0; est = 0;
            for (int c = 0; c < 3000; c++) begin
                if ($urandom_range(0, 3) == 0) begin
                    case ($urandom_range(0, 9))
                        0, 1, 2, 3: rq = '0;
                        9:          rq = 5'($urandom);
                        default:    rq = 5'(1 << $urandom_range(0, N - 1));
                    endcase
                end
                if ($urandom_range(0, 7) == 0)  md  = ~md;
                if ($urandom_range(0, 11) == 0) est = ~est;
                reset = ($urandom_range(0, 299) != 0);
                drive(($urandom_range(0, 7) == 0), est, rq, md, 3'($urandom));
                tick();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
